seed_packet_rx: RTL and testbench

SEED_PACKET_RX -- requirements
Module: seed_packet_rx

---
 rtl/snake_pkg.sv | 30 +++
 rtl/seed_packet_rx_if.sv | 35 +++
 rtl/seed_packet_rx.sv | 136 +++++++++++++
 tb/tb_seed_packet_rx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game blocks: game mode and remote seed link.
package snake_pkg;

    typedef enum logic [1:0] {
        ModeMenu,
        ModeGame,
        ModePause,
        ModeOver
    } game_mode;

    localparam logic [7:0]  SEED_HDR     = 8'hA5;
    localparam int unsigned SEED_TIMEOUT = 75000;  // 1 ms at 75 MHz

    typedef enum logic [1:0] {
        StIdle,
        StGotHdr,
        StGotX,
        StGotY
    } seed_rx_state;

    // Payload bytes carry a 5-bit value with the top three bits clear.
    function automatic logic is_seed_byte(input logic [7:0] b);
        return b[7:5] == 3'b000;
    endfunction

    function automatic logic [7:0] seed_checksum(input logic [4:0] x, input logic [4:0] y);
        return SEED_HDR ^ {3'b000, x} ^ {3'b000, y};
    endfunction

endpackage

// File: rtl/seed_packet_rx_if.sv
// Byte stream in, remote seed/status out, for the seed packet receiver.
interface seed_packet_rx_if;

    logic [7:0]           rx_data;
    logic                 rx_valid;
    snake_pkg::game_mode  mode;
    logic [4:0]           seed_x;
    logic [4:0]           seed_y;
    logic                 seed_valid;
    logic                 remote_start;
    logic                 frame_err;

    modport master (
        output rx_data,
        output rx_valid,
        output mode,
        input  seed_x,
        input  seed_y,
        input  seed_valid,
        input  remote_start,
        input  frame_err
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  mode,
        output seed_x,
        output seed_y,
        output seed_valid,
        output remote_start,
        output frame_err
    );

endinterface

// File: rtl/seed_packet_rx.sv
// Receives 4-byte seed packets (hdr, x, y, xor checksum) from the UART and publishes
// the remote player's seeds and start flag; rejected or stalled packets pulse frame_err.
module seed_packet_rx
    import snake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = SEED_TIMEOUT
) (
    input logic             clk_75,
    input logic             rst,
    seed_packet_rx_if.slave bus
);

    localparam int unsigned     GapW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CYCLES - 1);
    localparam logic [GapW-1:0] GapMax  = GapW'(TIMEOUT_CYCLES);

    seed_rx_state    state_q, state_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [4:0]      x_q, x_d;
    logic [4:0]      y_q, y_d;
    logic [4:0]      seed_x_q, seed_x_d;
    logic [4:0]      seed_y_q, seed_y_d;
    logic            seed_valid_q, seed_valid_d;
    logic            remote_start_q, remote_start_d;
    logic            frame_err_q, frame_err_d;
    game_mode        prev_mode_q;
    logic            accept;

    always_comb begin
        state_d        = state_q;
        gap_d          = gap_q;
        x_d            = x_q;
        y_d            = y_q;
        seed_x_d       = seed_x_q;
        seed_y_d       = seed_y_q;
        seed_valid_d   = 1'b0;
        frame_err_d    = 1'b0;
        remote_start_d = remote_start_q;
        accept         = 1'b0;

        if (prev_mode_q == ModeGame && bus.mode != ModeGame) begin
            remote_start_d = 1'b0;
        end

        // A byte always beats a coincident timeout.
        if (bus.rx_valid) begin
            gap_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (bus.rx_data == SEED_HDR) begin
                        state_d = StGotHdr;
                    end
                end
                StGotHdr: begin
                    if (is_seed_byte(bus.rx_data)) begin
                        x_d     = bus.rx_data[4:0];
                        state_d = StGotX;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = (bus.rx_data == SEED_HDR) ? StGotHdr : StIdle;
                    end
                end
                StGotX: begin
                    if (is_seed_byte(bus.rx_data)) begin
                        y_d     = bus.rx_data[4:0];
                        state_d = StGotY;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = (bus.rx_data == SEED_HDR) ? StGotHdr : StIdle;
                    end
                end
                StGotY: begin
                    // Checksum byte is compared verbatim; 0xA5 here is data, not a header.
                    state_d = StIdle;
                    if (bus.rx_data == seed_checksum(x_q, y_q)) begin
                        accept = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (gap_q == GapLast) begin
                state_d     = StIdle;
                gap_d       = '0;
                frame_err_d = 1'b1;
            end else if (gap_q != GapMax) begin
                gap_d = gap_q + GapW'(1);
            end
        end else begin
            gap_d = '0;
        end

        // Seeds are frozen while a game is running; the packet is dropped quietly.
        if (accept && bus.mode != ModeGame) begin
            seed_x_d       = x_q;
            seed_y_d       = y_q;
            seed_valid_d   = 1'b1;
            remote_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk_75) begin
        if (rst) begin
            state_q        <= StIdle;
            gap_q          <= '0;
            x_q            <= '0;
            y_q            <= '0;
            seed_x_q       <= '0;
            seed_y_q       <= '0;
            seed_valid_q   <= 1'b0;
            remote_start_q <= 1'b0;
            frame_err_q    <= 1'b0;
            prev_mode_q    <= ModeMenu;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            x_q            <= x_d;
            y_q            <= y_d;
            seed_x_q       <= seed_x_d;
            seed_y_q       <= seed_y_d;
            seed_valid_q   <= seed_valid_d;
            remote_start_q <= remote_start_d;
            frame_err_q    <= frame_err_d;
            prev_mode_q    <= bus.mode;
        end
    end

    assign bus.seed_x       = seed_x_q;
    assign bus.seed_y       = seed_y_q;
    assign bus.seed_valid   = seed_valid_q;
    assign bus.remote_start = remote_start_q;
    assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_seed_packet_rx.sv
// Bench for seed_packet_rx: directed packet scenarios plus random byte streams,
// checked every cycle against a packet-buffer model of the receiver.
module tb_seed_packet_rx;
    import snake_pkg::*;

    localparam int unsigned T = 20;

    logic clk_75 = 1'b0;
    logic rst    = 1'b1;

    seed_packet_rx_if bus ();

    seed_packet_rx #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_75(clk_75),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_75 = ~clk_75;

    int       n_cmp   = 0;
    int       n_err   = 0;
    int       sv_seen = 0;
    int       fe_seen = 0;
    game_mode cur_mode = ModeMenu;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp_v);
        end
    endtask

    // Model: the open packet is a list of bytes received so far; outputs follow from it.
    logic [7:0] pkt [3];
    int         plen      = 0;
    int         gap       = 0;
    game_mode   prev_mode = ModeMenu;
    logic [4:0] exp_sx    = '0;
    logic [4:0] exp_sy    = '0;
    logic       exp_sv    = 1'b0;
    logic       exp_rs    = 1'b0;
    logic       exp_fe    = 1'b0;
    bit         model_ok  = 1'b0;

    always @(posedge clk_75) begin : model
        logic [7:0] d;
        logic       acc;
        d   = bus.rx_data;
        acc = 1'b0;
        if (rst) begin
            plen = 0; gap = 0; prev_mode = ModeMenu;
            exp_sx = '0; exp_sy = '0; exp_sv = 1'b0; exp_rs = 1'b0; exp_fe = 1'b0;
            model_ok = 1'b1;
        end else begin
            exp_sv = 1'b0;
            exp_fe = 1'b0;
            if (bus.rx_valid) begin
                gap = 0;
                if (plen == 0) begin
                    if (d == 8'hA5) begin pkt[0] = d; plen = 1; end
                end else if (plen == 3) begin
                    if (d == (pkt[0] ^ pkt[1] ^ pkt[2])) acc = 1'b1;
                    else exp_fe = 1'b1;
                    plen = 0;
                end else if (d < 8'h20) begin
                    pkt[plen] = d;
                    plen++;
                end else begin
                    exp_fe = 1'b1;
                    plen   = (d == 8'hA5) ? 1 : 0;
                end
            end else if (plen != 0) begin
                gap++;
                if (gap == int'(T)) begin plen = 0; gap = 0; exp_fe = 1'b1; end
            end
            if (prev_mode == ModeGame && bus.mode != ModeGame) exp_rs = 1'b0;
            if (acc && bus.mode != ModeGame) begin
                exp_sx = pkt[1][4:0];
                exp_sy = pkt[2][4:0];
                exp_sv = 1'b1;
                exp_rs = 1'b1;
            end
            prev_mode = bus.mode;
        end
    end

    always @(negedge clk_75) begin
        if (model_ok) begin
            chk("seed_x",       32'(bus.seed_x),       32'(exp_sx));
            chk("seed_y",       32'(bus.seed_y),       32'(exp_sy));
            chk("seed_valid",   32'(bus.seed_valid),   32'(exp_sv));
            chk("remote_start", 32'(bus.remote_start), 32'(exp_rs));
            chk("frame_err",    32'(bus.frame_err),    32'(exp_fe));
            chk("excl",         32'(bus.seed_valid & bus.frame_err), 32'd0);
            if (bus.seed_valid === 1'b1) sv_seen++;
            if (bus.frame_err === 1'b1) fe_seen++;
        end
    end

    task automatic drive(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk_75);
        rst          = r;
        bus.rx_valid = v;
        bus.rx_data  = d;
        bus.mode     = cur_mode;
        #1;
    endtask

    task automatic byte_in(input logic [7:0] d);
        drive(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic gap_r();
        int g;
        g = $urandom_range(0, 11);
        if (g == 11) idle(int'(T) + $urandom_range(0, 3) - 1);
        else if (g > 7) idle(g);
    endtask

    task automatic send_pkt();
        logic [7:0] x, y, c;
        x = 8'($urandom_range(0, 31));
        y = 8'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) x = 8'($urandom);
        c = 8'hA5 ^ x ^ y;
        if ($urandom_range(0, 3) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
        byte_in(8'hA5); gap_r();
        byte_in(x);     gap_r();
        byte_in(y);     gap_r();
        byte_in(c);
    endtask

    initial begin : stim
        int sv0, fe0, k;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.mode     = ModeMenu;
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        chk("rst_seed_x",       32'(bus.seed_x),       32'd0);
        chk("rst_seed_y",       32'(bus.seed_y),       32'd0);
        chk("rst_seed_valid",   32'(bus.seed_valid),   32'd0);
        chk("rst_remote_start", 32'(bus.remote_start), 32'd0);
        chk("rst_frame_err",    32'(bus.frame_err),    32'd0);

        // Basic accept in menu.
        sv0 = sv_seen;
        byte_in(8'hA5); byte_in(8'h05); byte_in(8'h0C); byte_in(8'hAC);
        idle(1);
        chk("acc_seed_valid", 32'(bus.seed_valid),   32'd1);
        chk("acc_seed_x",     32'(bus.seed_x),       32'd5);
        chk("acc_seed_y",     32'(bus.seed_y),       32'd12);
        chk("acc_remote",     32'(bus.remote_start), 32'd1);
        chk("model_seed_x",   32'(exp_sx),           32'd5);
        idle(1);
        chk("acc_pulse_end",  32'(bus.seed_valid),   32'd0);
        chk("acc_pulses",     32'(sv_seen - sv0),    32'd1);

        // Bad checksum.
        sv0 = sv_seen; fe0 = fe_seen;
        byte_in(8'hA5); byte_in(8'h05); byte_in(8'h0C); byte_in(8'hAD);
        idle(2);
        chk("badck_fe",     32'(fe_seen - fe0), 32'd1);
        chk("badck_sv",     32'(sv_seen - sv0), 32'd0);
        chk("badck_seed_x", 32'(bus.seed_x),    32'd5);

        // Header resync, then wrong checksum 6E, then correct AD.
        fe0 = fe_seen;
        byte_in(8'hA5); byte_in(8'hA5); byte_in(8'h1E);
        chk("resync_fe", 32'(bus.frame_err), 32'd1);
        byte_in(8'h16); byte_in(8'h6E);
        idle(2);
        chk("resync_6e_fe", 32'(fe_seen - fe0), 32'd2);
        chk("resync_6e_x",  32'(bus.seed_x),    32'd5);
        sv0 = sv_seen; fe0 = fe_seen;
        byte_in(8'hA5); byte_in(8'hA5); byte_in(8'h1E); byte_in(8'h16); byte_in(8'hAD);
        idle(2);
        chk("resync_fe1", 32'(fe_seen - fe0), 32'd1);
        chk("resync_sv",  32'(sv_seen - sv0), 32'd1);
        chk("resync_x",   32'(bus.seed_x),    32'd30);
        chk("resync_y",   32'(bus.seed_y),    32'd22);

        // Timeout after exactly T idle cycles; trailing bytes discarded silently.
        sv0 = sv_seen; fe0 = fe_seen;
        byte_in(8'hA5); byte_in(8'h03);
        idle(int'(T));
        chk("to_early", 32'(fe_seen - fe0), 32'd0);
        idle(1);
        chk("to_fe_now", 32'(bus.frame_err), 32'd1);
        byte_in(8'h0C); byte_in(8'hAC);
        idle(2);
        chk("to_fe_once", 32'(fe_seen - fe0), 32'd1);
        chk("to_no_sv",   32'(sv_seen - sv0), 32'd0);

        // Byte arriving on the timeout cycle wins.
        sv0 = sv_seen; fe0 = fe_seen;
        byte_in(8'hA5); byte_in(8'h03);
        idle(int'(T) - 1);
        byte_in(8'h0C); byte_in(8'hAA);
        idle(1);
        chk("edge_sv", 32'(bus.seed_valid), 32'd1);
        chk("edge_x",  32'(bus.seed_x),     32'd3);
        chk("edge_fe", 32'(fe_seen - fe0),  32'd0);

        // Seeds frozen during GAME; remote_start drops one cycle after leaving GAME.
        sv0 = sv_seen; fe0 = fe_seen;
        cur_mode = ModeGame;
        idle(1);
        byte_in(8'hA5); byte_in(8'h01); byte_in(8'h02); byte_in(8'hA6);
        idle(2);
        chk("game_x",      32'(bus.seed_x),       32'd3);
        chk("game_sv",     32'(sv_seen - sv0),    32'd0);
        chk("game_fe",     32'(fe_seen - fe0),    32'd0);
        chk("game_remote", 32'(bus.remote_start), 32'd1);
        cur_mode = ModeMenu;
        idle(1);
        chk("leave_hold", 32'(bus.remote_start), 32'd1);
        idle(1);
        chk("leave_fall", 32'(bus.remote_start), 32'd0);

        // Accept on the same cycle as leaving GAME sets remote_start.
        cur_mode = ModeGame;
        idle(1);
        byte_in(8'hA5); byte_in(8'h01); byte_in(8'h02);
        cur_mode = ModeMenu;
        byte_in(8'hA6);
        idle(1);
        chk("setwins_remote", 32'(bus.remote_start), 32'd1);
        chk("setwins_x",      32'(bus.seed_x),       32'd1);
        chk("setwins_y",      32'(bus.seed_y),       32'd2);

        // Reset mid-packet.
        sv0 = sv_seen; fe0 = fe_seen;
        byte_in(8'hA5); byte_in(8'h05);
        drive(1'b1, 1'b0, 8'h00);
        byte_in(8'h0C); byte_in(8'hAC);
        idle(2);
        chk("rstmid_x",      32'(bus.seed_x),       32'd0);
        chk("rstmid_y",      32'(bus.seed_y),       32'd0);
        chk("rstmid_remote", 32'(bus.remote_start), 32'd0);
        chk("rstmid_fe",     32'(fe_seen - fe0),    32'd0);
        chk("rstmid_sv",     32'(sv_seen - sv0),    32'd0);

        // Random traffic.
        for (int it = 0; it < 400; it++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2, 3, 4: send_pkt();
                5: byte_in(8'($urandom));
                6: idle($urandom_range(0, int'(T) + 8));
                7: cur_mode = game_mode'($urandom_range(0, 3));
                8: begin
                    if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b0, 8'($urandom));
                    else byte_in(8'hA5);
                end
                default: begin byte_in(8'hA5); byte_in(8'hA5); end
            endcase
        end
        idle(int'(T) + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
